// File: rtl/fir_peak_detector_if.sv
// Sample stream in, peak report out, between the FIR output stage and the peak detector.
// The master drives samples and threshold; the slave returns status and the registered result.
interface fir_peak_detector_if #(
    parameter int DATA_WIDTH  = 19,
    parameter int INDEX_WIDTH = 6
);
    logic                          frame_start;
    logic                          data_valid;
    logic signed [DATA_WIDTH-1:0]  data_in;
    logic        [DATA_WIDTH-2:0]  threshold;
    logic                          busy;
    logic                          peak_valid;
    logic                          peak_found;
    logic        [DATA_WIDTH-2:0]  peak_value;
    logic        [INDEX_WIDTH-1:0] peak_index;

    modport master (
        output frame_start, data_valid, data_in, threshold,
        input  busy, peak_valid, peak_found, peak_value, peak_index
    );

    modport slave (
        input  frame_start, data_valid, data_in, threshold,
        output busy, peak_valid, peak_found, peak_value, peak_index
    );
endinterface

// File: rtl/fir_peak_detector.sv
// Searches each fixed-length window of FIR samples for the largest magnitude at or above
// a threshold and reports its value and index once per window.
module fir_peak_detector #(
    parameter int DATA_WIDTH    = 19,
    parameter int WINDOW_LENGTH = 64,
    parameter int INDEX_WIDTH   = $clog2(WINDOW_LENGTH)
) (
    input logic               clock,
    input logic               reset_n,
    fir_peak_detector_if.slave bus
);
    localparam int MAG_WIDTH = DATA_WIDTH - 1;
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(WINDOW_LENGTH - 1);

    typedef enum logic [1:0] {IDLE, SEARCH, REPORT} state_t;

    state_t                  state_q, state_d;
    logic [INDEX_WIDTH-1:0]  count_q, count_d;
    logic [MAG_WIDTH-1:0]    max_q, max_d;
    logic [INDEX_WIDTH-1:0]  maxIndex_q, maxIndex_d;
    logic                    found_q, found_d;
    logic                    peakFound_q, peakFound_d;
    logic [MAG_WIDTH-1:0]    peakValue_q, peakValue_d;
    logic [INDEX_WIDTH-1:0]  peakIndex_q, peakIndex_d;

    logic signed [DATA_WIDTH:0] sampleExt;
    logic signed [DATA_WIDTH:0] sampleNeg;
    logic        [DATA_WIDTH:0] absVal;
    logic [MAG_WIDTH-1:0]       mag;

    logic                    accept;
    logic                    lastSample;
    logic                    qualify;
    logic [INDEX_WIDTH-1:0]  countEff;
    logic [MAG_WIDTH-1:0]    maxEff;
    logic [INDEX_WIDTH-1:0]  maxIndexEff;
    logic                    foundEff;
    logic [MAG_WIDTH-1:0]    maxNew;
    logic [INDEX_WIDTH-1:0]  maxIndexNew;
    logic                    foundNew;

    // Negate one bit wider than the sample so the most negative input cannot wrap,
    // then clamp it to the largest representable magnitude.
    always_comb begin
        sampleExt = {bus.data_in[DATA_WIDTH-1], bus.data_in};
        sampleNeg = -sampleExt;
        absVal    = bus.data_in[DATA_WIDTH-1] ? sampleNeg : sampleExt;
        mag       = (absVal[DATA_WIDTH:MAG_WIDTH] != '0) ? '1 : absVal[MAG_WIDTH-1:0];
    end

    // A frame start makes this sample index 0 of a fresh window, so the running
    // search state is viewed as already cleared.
    always_comb begin
        accept      = bus.data_valid && (bus.frame_start || (state_q == SEARCH));
        countEff    = bus.frame_start ? '0 : count_q;
        maxEff      = bus.frame_start ? '0 : max_q;
        maxIndexEff = bus.frame_start ? '0 : maxIndex_q;
        foundEff    = bus.frame_start ? 1'b0 : found_q;
        qualify     = accept && (mag >= bus.threshold) && (!foundEff || (mag > maxEff));
        lastSample  = accept && (countEff == LAST_INDEX);
        maxNew      = qualify ? mag : maxEff;
        maxIndexNew = qualify ? countEff : maxIndexEff;
        foundNew    = foundEff || qualify;
    end

    always_comb begin
        count_d     = count_q;
        max_d       = max_q;
        maxIndex_d  = maxIndex_q;
        found_d     = found_q;
        peakFound_d = peakFound_q;
        peakValue_d = peakValue_q;
        peakIndex_d = peakIndex_q;
        if (lastSample) begin
            peakFound_d = foundNew;
            peakValue_d = foundNew ? maxNew : '0;
            peakIndex_d = foundNew ? maxIndexNew : '0;
            count_d     = '0;
            max_d       = '0;
            maxIndex_d  = '0;
            found_d     = 1'b0;
        end else if (bus.frame_start || accept) begin
            count_d     = accept ? countEff + INDEX_WIDTH'(1) : '0;
            max_d       = maxNew;
            maxIndex_d  = maxIndexNew;
            found_d     = foundNew;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.frame_start) state_d = SEARCH;
            end
            SEARCH: begin
                if (bus.frame_start)  state_d = SEARCH;
                else if (lastSample)  state_d = REPORT;
            end
            REPORT: begin
                state_d = bus.frame_start ? SEARCH : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = (state_q == SEARCH);
        bus.peak_valid = (state_q == REPORT);
        bus.peak_found = peakFound_q;
        bus.peak_value = peakValue_q;
        bus.peak_index = peakIndex_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            max_q       <= '0;
            maxIndex_q  <= '0;
            found_q     <= 1'b0;
            peakFound_q <= 1'b0;
            peakValue_q <= '0;
            peakIndex_q <= '0;
        end else begin
            count_q     <= count_d;
            max_q       <= max_d;
            maxIndex_q  <= maxIndex_d;
            found_q     <= found_d;
            peakFound_q <= peakFound_d;
            peakValue_q <= peakValue_d;
            peakIndex_q <= peakIndex_d;
        end
    end
endmodule

// File: tb/tb_fir_peak_detector.sv
// Directed windows of eight samples; expected reports are queued by the stimulus and
// popped by a monitor whenever peak_valid is seen.
module tb_fir_peak_detector;
    logic clock;
    logic reset_n;
    int   cycleCount;
    int   compared;
    int   mismatched;

    typedef struct {
        logic        found;
        logic [17:0] value;
        logic [2:0]  index;
        int          cycle;
    } exp_t;

    exp_t expQ[$];
    logic signed [18:0] vec [8];

    fir_peak_detector_if #(.DATA_WIDTH(19), .INDEX_WIDTH(3)) bus ();

    fir_peak_detector #(.DATA_WIDTH(19), .WINDOW_LENGTH(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cycleCount = 0;
    always @(posedge clock) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    task automatic applyStimulus(input logic fs, input logic dv, input logic signed [18:0] d);
        @(posedge clock);
        #1;
        bus.frame_start = fs;
        bus.data_valid  = dv;
        bus.data_in     = d;
    endtask

    // Drives vec as one window starting with frame_start; the report is due one edge
    // after the last sample is accepted.
    task automatic sendWindow(input int gap, input logic expFound, input logic [17:0] expValue,
                              input logic [2:0] expIndex, input bit fromReport);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i == 0, 1'b1, vec[i]);
            if (i == 0 && fromReport) checkOutput("busyInReport", {31'd0, bus.busy}, 32'd0);
            if (i > 0) checkOutput("busyInSearch", {31'd0, bus.busy}, 32'd1);
            if (i == 7) begin
                e.found = expFound;
                e.value = expValue;
                e.index = expIndex;
                e.cycle = cycleCount + 1;
                expQ.push_back(e);
            end else begin
                for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 19'sd0);
            end
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 19'sd0);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (reset_n === 1'b1 && bus.peak_valid !== 1'b0) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpectedReport: got peak_valid=%b at cycle %0d, expected no report",
                         bus.peak_valid, cycleCount);
            end else begin
                e = expQ.pop_front();
                checkOutput("peakFound", {31'd0, bus.peak_found}, {31'd0, e.found});
                checkOutput("peakValue", {14'd0, bus.peak_value}, {14'd0, e.value});
                checkOutput("peakIndex", {29'd0, bus.peak_index}, {29'd0, e.index});
                checkOutput("reportCycle", cycleCount, e.cycle);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cycleCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared        = 0;
        mismatched      = 0;
        reset_n         = 1'b0;
        bus.frame_start = 1'b0;
        bus.data_valid  = 1'b0;
        bus.data_in     = '0;
        bus.threshold   = '0;

        #12;
        checkOutput("resetBusy",      {31'd0, bus.busy},       32'd0);
        checkOutput("resetPeakValid", {31'd0, bus.peak_valid}, 32'd0);
        checkOutput("resetPeakFound", {31'd0, bus.peak_found}, 32'd0);
        checkOutput("resetPeakValue", {14'd0, bus.peak_value}, 32'd0);
        checkOutput("resetPeakIndex", {29'd0, bus.peak_index}, 32'd0);
        idleCycles(1);
        reset_n = 1'b1;

        // Reset asserted mid-window, then valid data with no frame start must be ignored
        bus.threshold = 18'd100;
        applyStimulus(1'b1, 1'b1, 19'sd500);
        applyStimulus(1'b0, 1'b1, 19'sd600);
        applyStimulus(1'b0, 1'b1, 19'sd700);
        checkOutput("busyBeforeReset", {31'd0, bus.busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1 checkOutput("busyDuringReset", {31'd0, bus.busy}, 32'd0);
        applyStimulus(1'b0, 1'b1, 19'sd300);
        applyStimulus(1'b0, 1'b1, 19'sd300);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 19'(1000 + i));
            checkOutput("idleBusy", {31'd0, bus.busy}, 32'd0);
        end
        checkOutput("idlePeakFound", {31'd0, bus.peak_found}, 32'd0);
        checkOutput("idlePeakValue", {14'd0, bus.peak_value}, 32'd0);
        idleCycles(2);

        // Single peak
        bus.threshold = 18'd100;
        vec = '{19'sd5, -19'sd20, 19'sd300, -19'sd450, 19'sd40, 19'sd0, 19'sd7, 19'sd9};
        sendWindow(0, 1'b1, 18'd450, 3'd3, 1'b0);
        idleCycles(4);
        checkOutput("holdPeakValue", {14'd0, bus.peak_value}, 32'd450);
        checkOutput("holdPeakIndex", {29'd0, bus.peak_index}, 32'd3);

        // Equal magnitudes keep the earliest index; gaps hold state
        vec = '{19'sd0, 19'sd200, 19'sd0, -19'sd200, 19'sd0, 19'sd0, 19'sd0, 19'sd0};
        sendWindow(3, 1'b1, 18'd200, 3'd1, 1'b0);
        idleCycles(3);

        // Most negative sample saturates and still meets the maximum threshold
        bus.threshold = 18'd262143;
        vec = '{19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, -19'sd262144, 19'sd262143, 19'sd0};
        sendWindow(0, 1'b1, 18'd262143, 3'd5, 1'b0);
        idleCycles(3);

        // Nothing meets the threshold
        bus.threshold = 18'd11;
        vec = '{19'sd10, 19'sd10, 19'sd10, 19'sd10, 19'sd10, 19'sd10, 19'sd10, 19'sd10};
        sendWindow(0, 1'b0, 18'd0, 3'd0, 1'b0);
        idleCycles(3);

        // Restart after four samples; the aborted window must not report or leak its max
        bus.threshold = 18'd100;
        applyStimulus(1'b1, 1'b1, 19'sd500);
        applyStimulus(1'b0, 1'b1, 19'sd1);
        applyStimulus(1'b0, 1'b1, 19'sd2);
        applyStimulus(1'b0, 1'b1, 19'sd3);
        vec = '{19'sd120, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd130};
        sendWindow(0, 1'b1, 18'd130, 3'd7, 1'b0);
        idleCycles(3);

        // Back-to-back windows with frame_start during the report cycle
        bus.threshold = 18'd50;
        vec = '{19'sd0, 19'sd0, 19'sd60, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0};
        sendWindow(0, 1'b1, 18'd60, 3'd2, 1'b0);
        vec = '{19'sd77, 19'sd10, -19'sd20, 19'sd30, 19'sd0, 19'sd5, 19'sd1, 19'sd2};
        sendWindow(0, 1'b1, 18'd77, 3'd0, 1'b1);
        idleCycles(4);

        checkOutput("reportsPending", expQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
